rf_multiport: RTL and testbench
===============================

// Module: rf_multiport
// PURPOSE
//   Next-generation CPU register file: NUM_RD read ports, NUM_WR write ports, byte-enabled
//   writes, all on the rising edge of Clk. Registered reads (1-cycle latency); optional
//   write-to-read bypass. Hardwired-zero entry 0 and a sequential clear engine (Clr/Busy).
//   Sits between decode (read addresses) and writeback (write ports) of a multi-issue pipeline.
// PARAMETERS
//   WIDTH     32  data width in bits; must be a multiple of 8
//   DEPTH     32  number of entries; power of two, >= 2
//   NUM_RD    2   read ports
//   NUM_WR    2   write ports
//   ZERO_REG  1   1: entry 0 reads 0 and ignores writes; 0: entry 0 is ordinary
//   (localparams: AW = $clog2(DEPTH), BW = WIDTH/8)
// PORTS
//   Clk     in   1            clock; all state updates on the rising edge
//   Rst_n   in   1            asynchronous reset, active low
//   Ra      in   NUM_RD*AW    read addresses; port i = Ra[i*AW +: AW]
//   busR    out  NUM_RD*WIDTH read data; port i = busR[i*WIDTH +: WIDTH]
//   WrEn    in   NUM_WR       per-port write enable
//   Rw      in   NUM_WR*AW    write addresses
//   ByteEn  in   NUM_WR*BW    per-port byte enables; byte b written only if WrEn & ByteEn bit set
//   busW    in   NUM_WR*WIDTH write data
//   Clr     in   1            single-cycle request to start a sequential clear
//   Busy    out  1            high while the clear engine is running
// BEHAVIOUR
//   - Reset (Rst_n=0, asynchronous): all entries 0, busR 0, Busy 0, FSM IDLE, clear index 0.
//     Reset asserted mid-clear aborts the sweep; the file is fully zero on release.
//   - Write: on posedge, each port with WrEn=1 updates enabled bytes of entry Rw.
//     Same-address conflict: per byte, the highest-index enabled port wins; lower ports'
//     disabled bytes do not mask higher ports. ByteEn all-zero with WrEn=1 is a no-op.
//   - Read: on posedge, busR[i] <= entry Ra[i]; visible the cycle after the address is
//     presented (1-cycle latency). Ports are independent; identical addresses are legal.
//   - ZERO_REG=1: writes to entry 0 dropped (incl. by the clear engine, which is harmless);
//     any read of address 0 returns 0 regardless of bypass.
//   - Clear FSM: IDLE -> CLEAR on Clr=1 (Busy rises next cycle). In CLEAR, entry idx is
//     zeroed each cycle, idx 0..DEPTH-1, then -> IDLE; Busy high exactly DEPTH cycles.
//     Clr while Busy ignored. Port writes during CLEAR are dropped (no write occurs);
//     reads continue and return current contents (swept entries read 0).
//   - Clear and port write same cycle in IDLE (Clr=1, WrEn=1): the write commits; the
//     sweep starts next cycle and will zero it.
// CONFIGURATION
//   RF_BYPASS_EN defined: a read whose Ra matches an address being written the same edge
//     returns the merged post-write value (per-byte priority above), i.e. write-first.
//   RF_BYPASS_EN undefined: read returns the pre-write value (read-first); new data visible
//     to a read issued the following cycle. Bypass never applies to address 0 when
//     ZERO_REG=1, nor to writes dropped during CLEAR.
// TESTING
//   1 Reset, then Ra0=5,Ra1=31 -> busR both 0; Busy 0.
//   2 WrEn0=1,Rw0=5,ByteEn0=4'hF,busW0=32'hDEADBEEF; next cycle Ra0=5 -> busR0=32'hDEADBEEF.
//   3 Same edge: port0 Rw=7 data 32'h11111111 BE=4'hF, port1 Rw=7 data 32'h22222222 BE=4'h3
//     -> entry 7 = 32'h11112222.
//   4 Write Rw=3 busW=32'hA5A5A5A5 while Ra0=3 (old 0): with RF_BYPASS_EN busR0=32'hA5A5A5A5
//     next cycle; without, busR0=0 then 32'hA5A5A5A5 one cycle later.
//   5 Write Rw=0 busW=32'hFFFFFFFF (ZERO_REG=1), read Ra=0 -> 0 in both macro builds.
//   6 Fill entries 1..31 nonzero, pulse Clr -> Busy high 32 cycles, write issued mid-sweep
//     dropped, all reads 0 after; Rst_n low at sweep cycle 10 -> Busy 0, file zero.

Source files
------------

// File: rtl/rf_multiport.sv
// ---------------------------------------------------------------------------
// rf_multiport
//   Multi-ported CPU register file for a multi-issue pipeline.
//   - NUM_RD registered read ports (1-cycle latency)
//   - NUM_WR byte-enabled write ports; on a same-address conflict, each byte
//     comes from the highest-index port that enables it
//   - optional hardwired-zero entry 0 (ZERO_REG)
//   - sequential clear engine: Clr starts a DEPTH-cycle sweep and Busy is
//     high while it runs; port writes are dropped during the sweep
//
// Build option:
//   RF_BYPASS_EN  defined   -> write-first: a read sees the same edge's writes
//                 undefined -> read-first: a read sees the pre-write contents
//
// Ports:
//   Clk     clock, rising edge
//   Rst_n   asynchronous reset, active low (clears every entry)
//   Ra      read addresses, port i = Ra[i*AW +: AW]
//   busR    read data, port i = busR[i*WIDTH +: WIDTH]
//   WrEn    per-port write enable
//   Rw      write addresses, port p = Rw[p*AW +: AW]
//   ByteEn  per-port byte enables, port p = ByteEn[p*BW +: BW]
//   busW    write data, port p = busW[p*WIDTH +: WIDTH]
//   Clr     one-cycle pulse that starts a clear sweep (ignored while Busy)
//   Busy    high while the clear sweep runs
// ---------------------------------------------------------------------------
module rf_multiport #(
    parameter int  WIDTH    = 32,
    parameter int  DEPTH    = 32,
    parameter int  NUM_RD   = 2,
    parameter int  NUM_WR   = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int BW       = WIDTH / 8
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [NUM_RD*AW-1:0]    Ra,
    output logic [NUM_RD*WIDTH-1:0] busR,
    input  logic [NUM_WR-1:0]       WrEn,
    input  logic [NUM_WR*AW-1:0]    Rw,
    input  logic [NUM_WR*BW-1:0]    ByteEn,
    input  logic [NUM_WR*WIDTH-1:0] busW,
    input  logic                    Clr,
    output logic                    Busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]       state;
    logic [AW-1:0]    clr_idx;

    logic [WIDTH-1:0] mem      [DEPTH];
    logic [WIDTH-1:0] wr_merge [DEPTH];  // contents after this edge's port writes
    logic [WIDTH-1:0] mem_next [DEPTH];  // contents after port writes and sweep
    logic [WIDTH-1:0] rd_next  [NUM_RD];
    logic [NUM_WR-1:0] wr_ok;

    assign Busy = (state == S_CLEAR);

    // A port write takes effect only outside the sweep, and never lands on
    // the hardwired-zero entry.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wr_ok[p] = WrEn[p] && (state == S_IDLE) &&
                       !((ZERO_REG != 0) && (Rw[p*AW +: AW] == '0));
        end
    end

    // Ports are applied in ascending order, so a higher port overwrites only
    // the bytes it enables and leaves a lower port's other bytes intact.
    // NOTE: every combinational output starts from a full default before the
    // conditional updates, so no path leaves it unassigned and no latch forms.
    always_comb begin
        wr_merge = mem;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_ok[p]) begin
                for (int b = 0; b < BW; b++) begin
                    if (ByteEn[p*BW + b]) begin
                        wr_merge[Rw[p*AW +: AW]][b*8 +: 8] = busW[p*WIDTH + b*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        mem_next = wr_merge;
        if (state == S_CLEAR) begin
            mem_next[clr_idx] = '0;
        end
    end

    // Read source: merged post-write data (write-first) or current contents
    // (read-first). The sweep is never bypassed; port writes are already
    // suppressed in wr_merge while it runs.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_next[i] = '0;
            if (!((ZERO_REG != 0) && (Ra[i*AW +: AW] == '0))) begin
`ifdef RF_BYPASS_EN
                rd_next[i] = wr_merge[Ra[i*AW +: AW]];
`else
                rd_next[i] = mem[Ra[i*AW +: AW]];
`endif
            end
        end
    end

    // NOTE: the file is built from flops rather than a RAM macro because
    // reset must clear every entry asynchronously; a RAM cannot do that.
    // NOTE: all state here updates with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
            busR    <= '0;
            state   <= S_IDLE;
            clr_idx <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= mem_next[e];
            end
            for (int i = 0; i < NUM_RD; i++) begin
                busR[i*WIDTH +: WIDTH] <= rd_next[i];
            end

            case (state)
                S_IDLE: begin
                    if (Clr) begin
                        state   <= S_CLEAR;
                        clr_idx <= '0;
                    end
                end
                S_CLEAR: begin
                    // The index wraps to 0 on the last entry, ready for the
                    // next sweep.
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AW'(DEPTH - 1)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// ---------------------------------------------------------------------------
// tb_rf_multiport
//   Self-checking bench for rf_multiport (default parameters). Each stimulus
//   cycle runs a behavioural model of the register file and queues the
//   expected read data and Busy; a monitor pops and compares after every
//   rising edge. Honours RF_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_rf_multiport;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = WIDTH / 8;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_RD*AW-1:0]    ra;
    logic [NUM_RD*WIDTH-1:0] bus_r;
    logic [NUM_WR-1:0]       wr_en;
    logic [NUM_WR*AW-1:0]    rw;
    logic [NUM_WR*BW-1:0]    byte_en;
    logic [NUM_WR*WIDTH-1:0] bus_w;
    logic                    clr;
    logic                    busy;

    rf_multiport #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)
    ) dut (
        .Clk(clk), .Rst_n(rst_n), .Ra(ra), .busR(bus_r), .WrEn(wr_en), .Rw(rw),
        .ByteEn(byte_en), .busW(bus_w), .Clr(clr), .Busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_RD-1:0][WIDTH-1:0] rd;
        logic                         busy;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain array of entries plus a count of sweep cycles left.
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_left;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < DEPTH; e++) m_mem[e] = '0;
        m_left = 0;
    endtask

    task automatic idle_inputs();
        wr_en   = '0;
        byte_en = '0;
        clr     = 1'b0;
    endtask

    task automatic set_wr(input int p, input int addr, input logic [BW-1:0] be,
                          input logic [WIDTH-1:0] data);
        wr_en[p]                = 1'b1;
        rw[p*AW +: AW]          = AW'(addr);
        byte_en[p*BW +: BW]     = be;
        bus_w[p*WIDTH +: WIDTH] = data;
    endtask

    task automatic set_rd(input int i, input int addr);
        ra[i*AW +: AW] = AW'(addr);
    endtask

    // Model one rising edge with the inputs currently driven, queue the
    // expected outputs, then advance to the next falling edge.
    task automatic step();
        logic [WIDTH-1:0] post [DEPTH];
        exp_t             e;
        int               a;
        post = m_mem;
        if (m_left == 0) begin
            for (int p = 0; p < NUM_WR; p++) begin
                a = int'(rw[p*AW +: AW]);
                if (wr_en[p] && a != 0) begin
                    for (int b = 0; b < BW; b++) begin
                        if (byte_en[p*BW + b]) post[a][b*8 +: 8] = bus_w[p*WIDTH + b*8 +: 8];
                    end
                end
            end
        end
        for (int i = 0; i < NUM_RD; i++) begin
            a = int'(ra[i*AW +: AW]);
`ifdef RF_BYPASS_EN
            e.rd[i] = (a == 0) ? '0 : post[a];
`else
            e.rd[i] = (a == 0) ? '0 : m_mem[a];
`endif
        end
        m_mem = post;
        if (m_left > 0) begin
            m_mem[DEPTH - m_left] = '0;
            m_left--;
        end else if (clr) begin
            m_left = DEPTH;
        end
        e.busy = (m_left > 0);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every edge with a queued expectation is compared.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < NUM_RD; i++) begin
                check($sformatf("busR%0d", i), bus_r[i*WIDTH +: WIDTH], e.rd[i]);
            end
            check("Busy", WIDTH'(busy), WIDTH'(e.busy));
        end
    end

    task automatic random_reads();
        for (int i = 0; i < NUM_RD; i++) set_rd(i, $urandom_range(0, DEPTH - 1));
    endtask

    task automatic fill_nonzero();
        for (int e = 1; e < DEPTH; e += 2) begin
            idle_inputs();
            random_reads();
            set_wr(0, e, '1, $urandom | 32'h1);
            if (e + 1 < DEPTH) set_wr(1, e + 1, '1, $urandom | 32'h1);
            step();
        end
        idle_inputs();
    endtask

    task automatic read_all();
        for (int e = 0; e < DEPTH; e += 2) begin
            idle_inputs();
            set_rd(0, e);
            set_rd(1, e + 1);
            step();
        end
    endtask

    task automatic pulse_clr();
        idle_inputs();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ra    = '0;
        rw    = '0;
        bus_w = '0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        #1;
        check("rst_busR0", bus_r[0 +: WIDTH], '0);
        check("rst_busR1", bus_r[WIDTH +: WIDTH], '0);
        check("rst_Busy", WIDTH'(busy), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh file reads zero.
        set_rd(0, 5); set_rd(1, 31); step();

        // Full-word write then read back.
        set_wr(0, 5, 4'hF, 32'hDEADBEEF); step();
        idle_inputs(); set_rd(0, 5); step();

        // Same-address conflict with partial byte enables.
        set_wr(0, 7, 4'hF, 32'h11111111);
        set_wr(1, 7, 4'h3, 32'h22222222); step();
        idle_inputs(); set_rd(0, 7); set_rd(1, 7); step();

        // Read of an entry written on the same edge (bypass behaviour).
        set_rd(0, 3); set_wr(0, 3, 4'hF, 32'hA5A5A5A5); step();
        idle_inputs(); step();

        // Hardwired zero entry.
        set_rd(0, 0); set_rd(1, 0); set_wr(1, 0, 4'hF, 32'hFFFFFFFF); step();
        idle_inputs(); step();

        // Enabled write with no bytes selected is a no-op.
        set_rd(0, 5); set_wr(0, 5, 4'h0, 32'h0BADF00D); step();
        idle_inputs(); step();

        // Clear and write on the same idle cycle: the write commits, then the
        // sweep removes it.
        set_wr(0, 12, 4'hF, 32'hCAFEF00D); clr = 1'b1; set_rd(0, 12); step();
        idle_inputs(); set_rd(0, 12);
        for (int k = 0; k < DEPTH; k++) step();
        step();

        // Randomised traffic, with an occasional clear.
        for (int n = 0; n < 300; n++) begin
            idle_inputs();
            random_reads();
            for (int p = 0; p < NUM_WR; p++) begin
                if ($urandom_range(0, 2) != 0)
                    set_wr(p, $urandom_range(0, DEPTH - 1), BW'($urandom), $urandom);
            end
            clr = ($urandom_range(0, 59) == 0);
            step();
        end
        idle_inputs();
        for (int k = 0; k < DEPTH + 1; k++) begin random_reads(); step(); end

        // Full sweep: dropped write and ignored Clr mid-sweep, then all zero.
        fill_nonzero();
        read_all();
        pulse_clr();
        for (int k = 0; k < DEPTH; k++) begin
            idle_inputs();
            random_reads();
            if (k == 3) clr = 1'b1;
            if (k == 5) set_wr(0, 9, 4'hF, 32'h12345678);
            if (k == 20) set_wr(1, 2, 4'hF, 32'h87654321);
            step();
        end
        idle_inputs();
        read_all();

        // Reset in the middle of a sweep aborts it and leaves the file zero.
        fill_nonzero();
        pulse_clr();
        for (int k = 0; k < 10; k++) begin random_reads(); step(); end
        rst_n = 1'b0;
        #1;
        check("midrst_busR0", bus_r[0 +: WIDTH], '0);
        check("midrst_busR1", bus_r[WIDTH +: WIDTH], '0);
        check("midrst_Busy", WIDTH'(busy), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_all();
        step();

        @(posedge clk);
        #2;
        check("sb_drain", WIDTH'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
